vec_operand_loader: RTL and testbench
=====================================

# vec_operand_loader

Serial-to-parallel operand packer that sits in front of the vector multiplier and adder-tree datapath. It accepts one signed operand element per cycle over a valid/ready stream and assembles MATRIX_SIZE elements into the flattened lane vector the multiplier array consumes. It presents completed vectors over a second valid/ready interface. Ping-pong double buffering lets the next vector load while the current one is held under backpressure.

## Interface

- DATA_BW, default 8: operand element width in bits (signed).
- MATRIX_SIZE, default 8: lanes per vector; must be a power of two, at least 2.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader can accept an element this cycle.
- in_data  input  DATA_BW  operand element.
- in_last  input  1  early end of vector; used only when VEC_LOADER_ZERO_PAD_EN is defined, ignored otherwise.
- out_valid  output  1  out_data_flat holds a complete vector.
- out_ready  input  1  downstream accepts the vector.
- out_data_flat  output  DATA_BW*MATRIX_SIZE  lane i occupies bits [i*DATA_BW +: DATA_BW].

## Operation

- Storage: two vector buffers, B0 and B1. Each buffer has a registered full flag.
- Write pointer wsel selects the buffer being filled. Read pointer rsel selects the buffer being presented. lane_cnt, of width log2(MATRIX_SIZE), indexes the next lane.
- Per-buffer states:
  - EMPTY -> FILLING on the first accept.
  - FILLING -> FULL on the last-lane accept.
  - FULL -> EMPTY on the output handshake.
- Input accept occurs when in_valid && in_ready.
  - The element is written to lane lane_cnt of buffer wsel, and lane_cnt increments.
  - The first element accepted after reset or after a completed vector lands in lane 0.
- On an accept with lane_cnt == MATRIX_SIZE-1:
  - full[wsel] is set, lane_cnt wraps to 0, and wsel toggles.
- in_ready = !full[wsel]. It depends only on registered state, with no combinational path from out_ready.
- out_valid = full[rsel]. out_data_flat is driven from buffer rsel.
- Output handshake (out_valid && out_ready): full[rsel] is cleared and rsel toggles.
- Simultaneous input completion and output handshake on different buffers: both take effect in the same cycle.
- A buffer freed by a handshake becomes writable on the next cycle.
- Data is stored unmodified, with no sign extension or arithmetic. Width growth happens downstream.
- Vector order is preserved: vectors leave in acceptance order, with no drop or duplication.

## Timing

- Reset values:
  - in_ready = 1, out_valid = 0, out_data_flat = 0.
  - Both buffers zeroed, both full flags = 0.
  - wsel = rsel = 0, lane_cnt = 0.
- Reset asserted mid-fill or while a vector is held discards all contents. The first element after release goes to lane 0 of B0.
- Latency: out_valid rises the cycle after the last-lane element is accepted.
- Throughput with out_ready held at 1: one vector per MATRIX_SIZE cycles. in_ready never deasserts.
- Backpressure:
  - Both buffers full -> in_ready = 0.
  - While out_valid && !out_ready, out_data_flat and out_valid are held stable.
- in_data is ignored when in_ready = 0, even if in_valid = 1.

## Configuration

- VEC_LOADER_ZERO_PAD_EN, when defined:
  - An accept with in_last = 1 at lane k < MATRIX_SIZE-1 writes in_data to lane k and zero to lanes k+1..MATRIX_SIZE-1 in the same cycle.
  - It then sets full[wsel], resets lane_cnt to 0, and toggles wsel.
  - in_last at lane MATRIX_SIZE-1 behaves as a normal completion.
- VEC_LOADER_ZERO_PAD_EN, when not defined:
  - in_last is ignored.
  - A vector completes only after MATRIX_SIZE accepts.
  - No zero-fill logic is synthesized.

## Test plan

All scenarios use DATA_BW=8, MATRIX_SIZE=8.

- Reset: hold rst_n=0 -> in_ready=1, out_valid=0, out_data_flat=0x0000000000000000.
- Single vector: feed 0x01..0x08 with out_ready=1 -> out_valid=1 exactly one cycle after the 8th accept, with out_data_flat=0x0807060504030201.
- Backpressure: out_ready=0, feed 0x10..0x1F continuously.
  - in_ready falls after the 16th accept and the 17th element stalls.
  - out_data_flat holds 0x1716151413121110 stable.
  - Raising out_ready yields 0x1F1E1D1C1B1A1918 next, and in_ready returns 1 the following cycle.
- Sustained streaming: 4 back-to-back vectors, out_ready=1 -> in_ready is never 0, and 4 out_valid pulses occur exactly 8 cycles apart in input order.
- Zero pad:
  - With the macro defined, feed 0xA1, 0xA2, 0xA3 with in_last on 0xA3 -> out_data_flat=0x0000000000A3A2A1. The next element lands in lane 0.
  - Without the macro -> no output until 5 more accepts.
- Reset mid-fill: accept 5 elements, pulse rst_n low, then feed 0x21..0x28 -> a single vector 0x2827262524232221 with no remnants of the earlier elements.

Source files
------------

// File: rtl/vec_operand_loader_if.sv
// Operand stream (in_*) and packed-vector stream (out_*) of the vector operand loader.
// master: producer/consumer environment; slave: the loader itself.
interface vec_operand_loader_if #(
  parameter int unsigned DATA_BW     = 8,
  parameter int unsigned MATRIX_SIZE = 8
);
  logic                           in_valid;
  logic                           in_ready;
  logic [DATA_BW-1:0]             in_data;
  logic                           in_last;
  logic                           out_valid;
  logic                           out_ready;
  logic [DATA_BW*MATRIX_SIZE-1:0] out_data_flat;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data_flat
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data_flat
  );
endinterface

// File: rtl/vec_operand_loader.sv
// Serial-to-parallel operand packer with ping-pong double buffering.
// Optional early-end zero padding via `define VEC_LOADER_ZERO_PAD_EN.
module vec_operand_loader #(
  parameter int unsigned DATA_BW     = 8,
  parameter int unsigned MATRIX_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  vec_operand_loader_if.slave bus
);
  localparam int unsigned     LaneW    = $clog2(MATRIX_SIZE);
  localparam int unsigned     VecW     = DATA_BW * MATRIX_SIZE;
  localparam logic [LaneW-1:0] LastLane = LaneW'(MATRIX_SIZE - 1);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull} buf_state_e;

  buf_state_e       state_q [2];
  buf_state_e       state_d [2];
  logic [VecW-1:0]  vec_q   [2];
  logic [VecW-1:0]  vec_d   [2];
  logic             wsel_q, wsel_d;
  logic             rsel_q, rsel_d;
  logic [LaneW-1:0] lane_cnt_q, lane_cnt_d;

  logic [1:0] full;
  logic       accept;
  logic       out_fire;
  logic       early_last;
  logic       in_done;

  assign full[0] = (state_q[0] == StFull);
  assign full[1] = (state_q[1] == StFull);

  // Ready comes only from registered state; no path from out_ready.
  assign bus.in_ready      = ~full[wsel_q];
  assign bus.out_valid     = full[rsel_q];
  assign bus.out_data_flat = vec_q[rsel_q];

  assign accept   = bus.in_valid & ~full[wsel_q];
  assign out_fire = full[rsel_q] & bus.out_ready;

`ifdef VEC_LOADER_ZERO_PAD_EN
  assign early_last = bus.in_last;
`else
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
  assign early_last     = 1'b0;
`endif

  assign in_done = accept & ((lane_cnt_q == LastLane) | early_last);

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    wsel_d     = wsel_q;
    rsel_d     = rsel_q;
    lane_cnt_d = lane_cnt_q;

    // Read and write buffers differ whenever both fire, so the updates never collide.
    if (out_fire) begin
      state_d[rsel_q] = StEmpty;
      rsel_d          = ~rsel_q;
    end

    if (accept) begin
      for (int unsigned i = 0; i < MATRIX_SIZE; i++) begin
        if (LaneW'(i) == lane_cnt_q) begin
          vec_d[wsel_q][i*DATA_BW +: DATA_BW] = bus.in_data;
        end
`ifdef VEC_LOADER_ZERO_PAD_EN
        else if (bus.in_last && (LaneW'(i) > lane_cnt_q)) begin
          vec_d[wsel_q][i*DATA_BW +: DATA_BW] = '0;
        end
`endif
      end

      if (in_done) begin
        state_d[wsel_q] = StFull;
        wsel_d          = ~wsel_q;
        lane_cnt_d      = '0;
      end else begin
        state_d[wsel_q] = StFilling;
        lane_cnt_d      = lane_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= StEmpty;
      state_q[1] <= StEmpty;
      vec_q[0]   <= '0;
      vec_q[1]   <= '0;
      wsel_q     <= 1'b0;
      rsel_q     <= 1'b0;
      lane_cnt_q <= '0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      vec_q[0]   <= vec_d[0];
      vec_q[1]   <= vec_d[1];
      wsel_q     <= wsel_d;
      rsel_q     <= rsel_d;
      lane_cnt_q <= lane_cnt_d;
    end
  end

endmodule

// File: tb/tb_vec_operand_loader.sv
// Directed bench for vec_operand_loader with a vector scoreboard fed from observed accepts.
// Honours `define VEC_LOADER_ZERO_PAD_EN to match the DUT build.
module tb_vec_operand_loader;
  localparam int unsigned DW = 8;
  localparam int unsigned MS = 8;
  localparam int unsigned VW = DW * MS;

  logic clk;
  logic rst_n;

  vec_operand_loader_if #(.DATA_BW(DW), .MATRIX_SIZE(MS)) bus ();

  vec_operand_loader #(.DATA_BW(DW), .MATRIX_SIZE(MS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_cmp  = 0;
  int n_err  = 0;
  int cyc    = 0;
  int stalls = 0;

  logic [VW-1:0] exp_q [$];
  int            hs_cyc[$];
  logic [VW-1:0] mdl_vec  = '0;
  int            mdl_lane = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  // Leaves in_valid high; callers follow a burst with idle() in zero time.
  task automatic send(input logic [DW-1:0] d, input logic l);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && t < 200) begin
      tick();
      t++;
    end
    if (t > 0) stalls++;
    if (t >= 200) check("send_timeout", VW'(t), VW'(0));
    tick();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    mdl_vec  = '0;
    mdl_lane = 0;
    exp_q.delete();
    tick();
    tick();
    check("rst_in_ready", VW'(bus.in_ready), VW'(1));
    check("rst_out_valid", VW'(bus.out_valid), VW'(0));
    check("rst_out_data", bus.out_data_flat, VW'(0));
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    repeat (3) tick();
    check(tag, VW'(exp_q.size()), VW'(0));
  endtask

  // Scoreboard: pop/compare on output handshakes, build expected vectors from accepts.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_vec", VW'(exp_q.size()), VW'(1));
        end else begin
          check("sb_vec", bus.out_data_flat, exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        logic done;
        mdl_vec[mdl_lane*DW +: DW] = bus.in_data;
        mdl_lane++;
        done = (mdl_lane == MS);
`ifdef VEC_LOADER_ZERO_PAD_EN
        if (bus.in_last) done = 1'b1;
`endif
        if (done) begin
          exp_q.push_back(mdl_vec);
          mdl_vec  = '0;
          mdl_lane = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit (n_cmp=%0d)", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    tick();
    do_reset();

    // Single vector, one-cycle latency.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("sv_not_early", VW'(bus.out_valid), VW'(0));
      send(DW'(i + 1), 1'b0);
    end
    idle();
    check("sv_valid", VW'(bus.out_valid), VW'(1));
    check("sv_data", bus.out_data_flat, 64'h0807060504030201);
    tick();
    check("sv_valid_drop", VW'(bus.out_valid), VW'(0));
    drain("sv_drain");

    // Backpressure: both buffers fill, 17th element stalls, in_data ignored while stalled.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(DW'(8'h10 + i), 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h20;
    check("bp_ready_low", VW'(bus.in_ready), VW'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.in_data = 8'hEE;
      check("bp_stall", VW'(bus.in_ready), VW'(0));
      check("bp_hold_data", bus.out_data_flat, 64'h1716151413121110);
      check("bp_hold_valid", VW'(bus.out_valid), VW'(1));
    end
    idle();
    bus.out_ready = 1'b1;
    tick();
    check("bp_next_data", bus.out_data_flat, 64'h1F1E1D1C1B1A1918);
    check("bp_ready_back", VW'(bus.in_ready), VW'(1));
    drain("bp_drain");

    // Sustained streaming of four back-to-back vectors.
    hs_cyc.delete();
    stalls = 0;
    for (int v = 0; v < 4; v++) begin
      for (int l = 0; l < 8; l++) send(DW'(8'h40 + v * 8 + l), 1'b0);
    end
    idle();
    drain("st_drain");
    check("st_no_stall", VW'(stalls), VW'(0));
    check("st_count", VW'(hs_cyc.size()), VW'(4));
    if (hs_cyc.size() == 4) begin
      for (int k = 1; k < 4; k++) check("st_spacing", VW'(hs_cyc[k] - hs_cyc[k-1]), VW'(8));
    end

    // Early end of vector.
    do_reset();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b1);
    idle();
`ifdef VEC_LOADER_ZERO_PAD_EN
    check("zp_valid", VW'(bus.out_valid), VW'(1));
    check("zp_data", bus.out_data_flat, 64'h0000000000A3A2A1);
    drain("zp_drain");
    for (int i = 0; i < 8; i++) send(DW'(8'hB0 + i), 1'b0);
    idle();
    check("zp_next_lane0", bus.out_data_flat, 64'hB7B6B5B4B3B2B1B0);
    drain("zp_next_drain");
`else
    check("zp_ignored", VW'(bus.out_valid), VW'(0));
    for (int i = 0; i < 4; i++) send(DW'(8'hB0 + i), 1'b0);
    idle();
    check("zp_still_filling", VW'(bus.out_valid), VW'(0));
    send(8'hB4, 1'b0);
    idle();
    check("zp_full_valid", VW'(bus.out_valid), VW'(1));
    check("zp_full_data", bus.out_data_flat, 64'hB4B3B2B1B0A3A2A1);
    drain("zp_drain");
`endif

    // Reset mid-fill discards the partial vector.
    for (int i = 0; i < 5; i++) send(DW'(8'h55 + i), 1'b0);
    idle();
    do_reset();
    for (int i = 0; i < 8; i++) send(DW'(8'h21 + i), 1'b0);
    idle();
    check("rm_data", bus.out_data_flat, 64'h2827262524232221);
    drain("rm_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
